// File: rtl/riscv_pkg.sv
// Shared constants for the data-memory responder: access-size encodings,
// MMIO register offsets and the store byte-mask helper.
package riscv_pkg;

    localparam logic [2:0] SZ_B = 3'b001;
    localparam logic [2:0] SZ_H = 3'b010;
    localparam logic [2:0] SZ_W = 3'b100;

    localparam logic [4:0] MMIO_MTIME_LO    = 5'h00;
    localparam logic [4:0] MMIO_MTIME_HI    = 5'h04;
    localparam logic [4:0] MMIO_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MMIO_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] MMIO_TOHOST      = 5'h10;

    // Byte-lane mask of an access before it is shifted into position.
    function automatic logic [3:0] sizeMask(input logic [2:0] size);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = 4'b0001;
            SZ_H:    mask = 4'b0011;
            SZ_W:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// 64-bit machine timer: free-running mtime, store-only mtimecmp and the
// registered timer interrupt.
module dmem_timer
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_weMtimeLo,
    input  logic        i_weMtimeHi,
    input  logic        i_weCmpLo,
    input  logic        i_weCmpHi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_irq
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_irq;

    // A store to either mtime half replaces the increment for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);
            if (i_weMtimeLo) begin
                r_mtime <= {r_mtime[63:32], i_wdata};
            end else if (i_weMtimeHi) begin
                r_mtime <= {i_wdata, r_mtime[31:0]};
            end else begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (i_weCmpLo) begin
                r_mtimecmp[31:0] <= i_wdata;
            end
            if (i_weCmpHi) begin
                r_mtimecmp[63:32] <= i_wdata;
            end
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_irq      = r_irq;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder for the execute-stage load/store port: word RAM with
// byte-enable stores plus a small MMIO window (timer, mtimecmp, tohost).
module dmem_resp
    import riscv_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RAM_BASE  = 32'h0000_0000,
    parameter int               RAM_WORDS = 1024,
    parameter logic [XLEN-1:0]  MMIO_BASE = 32'h0200_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    output logic [XLEN-1:0] load_data_o,
    output logic            access_fault_o,
    output logic            timer_irq_o,
    output logic            tohost_v_o,
    output logic [XLEN-1:0] tohost_data_o
);

    localparam int              IDXW       = $clog2(RAM_WORDS);
    localparam logic [XLEN:0]   RAM_BYTES  = (XLEN+1)'(4 * RAM_WORDS);
    localparam logic [XLEN:0]   MMIO_BYTES = (XLEN+1)'(32);

    logic [XLEN-1:0] r_ram [RAM_WORDS];
    logic            r_tohostV;
    logic [XLEN-1:0] r_tohostData;

    logic [XLEN:0]   w_ramDiff;
    logic [XLEN:0]   w_mmioDiff;
    logic            w_ramHit;
    logic            w_mmioHit;
    logic [IDXW-1:0] w_idx;
    logic [4:0]      w_mmioSel;
    logic [4:0]      w_shift;
    logic            w_misaligned;
    logic            w_doStore;
    logic            w_ramWe;
    logic            w_mmioWe;
    logic [3:0]      w_byteEn;
    logic [XLEN-1:0] w_storeShifted;
    logic [XLEN-1:0] w_ramWord;
    logic [XLEN-1:0] w_mmioLoad;
    logic [63:0]     w_mtime;
    logic [63:0]     w_mtimecmp;

    // One extra bit makes an address below the base wrap far above the window.
    assign w_ramDiff  = {1'b0, adr_i} - {1'b0, RAM_BASE};
    assign w_mmioDiff = {1'b0, adr_i} - {1'b0, MMIO_BASE};
    assign w_ramHit   = (w_ramDiff < RAM_BYTES);
    assign w_mmioHit  = (w_mmioDiff < MMIO_BYTES);
    assign w_idx      = w_ramDiff[IDXW+1:2];
    assign w_mmioSel  = {adr_i[4:2], 2'b00};
    assign w_shift    = {adr_i[1:0], 3'b000};

    assign access_fault_o = adr_v_i & (~(w_ramHit | w_mmioHit)
                                       | (w_mmioHit & ~access_size_i[2])
                                       | (w_mmioHit & (adr_i[4:2] > 3'd4)));

    always_comb begin
        w_misaligned = 1'b0;
        case (access_size_i)
            SZ_H:    w_misaligned = adr_i[0];
            SZ_W:    w_misaligned = |adr_i[1:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // Misaligned RAM stores are silently dropped; the LSU traps them itself.
    assign w_doStore      = adr_v_i & is_store_i & ~access_fault_o & ~reset;
    assign w_ramWe        = w_doStore & w_ramHit & ~w_misaligned;
    assign w_mmioWe       = w_doStore & ~w_ramHit & w_mmioHit;
    assign w_byteEn       = sizeMask(access_size_i) << adr_i[1:0];
    assign w_storeShifted = store_data_i << w_shift;

    always_ff @(posedge clk) begin
        if (w_ramWe) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) begin
                    r_ram[w_idx][8*b +: 8] <= w_storeShifted[8*b +: 8];
                end
            end
        end
    end

    dmem_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_weMtimeLo (w_mmioWe & (w_mmioSel == MMIO_MTIME_LO)),
        .i_weMtimeHi (w_mmioWe & (w_mmioSel == MMIO_MTIME_HI)),
        .i_weCmpLo   (w_mmioWe & (w_mmioSel == MMIO_MTIMECMP_LO)),
        .i_weCmpHi   (w_mmioWe & (w_mmioSel == MMIO_MTIMECMP_HI)),
        .i_wdata     (store_data_i),
        .o_mtime     (w_mtime),
        .o_mtimecmp  (w_mtimecmp),
        .o_irq       (timer_irq_o)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tohostV    <= 1'b0;
            r_tohostData <= '0;
        end else begin
            r_tohostV <= w_mmioWe & (w_mmioSel == MMIO_TOHOST);
            if (w_mmioWe & (w_mmioSel == MMIO_TOHOST)) begin
                r_tohostData <= store_data_i;
            end
        end
    end

    assign tohost_v_o    = r_tohostV;
    assign tohost_data_o = r_tohostData;

    always_comb begin
        w_mmioLoad = '0;
        case (w_mmioSel)
            MMIO_MTIME_LO:    w_mmioLoad = w_mtime[31:0];
            MMIO_MTIME_HI:    w_mmioLoad = w_mtime[63:32];
            MMIO_MTIMECMP_LO: w_mmioLoad = w_mtimecmp[31:0];
            MMIO_MTIMECMP_HI: w_mmioLoad = w_mtimecmp[63:32];
            MMIO_TOHOST:      w_mmioLoad = r_tohostData;
            default:          w_mmioLoad = '0;
        endcase
    end

    assign w_ramWord = r_ram[w_idx];

    // Load data is right-justified; extension is left to the LSU.
    always_comb begin
        load_data_o = '0;
        if (adr_v_i & ~is_store_i & ~access_fault_o) begin
            load_data_o = w_ramHit ? (w_ramWord >> w_shift) : w_mmioLoad;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Randomized scoreboard bench for dmem_resp: a byte-addressed reference model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_dmem_resp;
    import riscv_pkg::*;

    localparam int          RAM_WORDS = 1024;
    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE = 32'h0200_0000;
    localparam logic [31:0] TOHOST    = MMIO_BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset;
    logic        adrV;
    logic [31:0] adr;
    logic        isStore;
    logic [31:0] storeData;
    logic [2:0]  accessSize;
    logic [31:0] loadData;
    logic        accessFault;
    logic        timerIrq;
    logic        tohostV;
    logic [31:0] tohostData;

    dmem_resp #(
        .XLEN      (32),
        .RAM_BASE  (RAM_BASE),
        .RAM_WORDS (RAM_WORDS),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .adr_v_i        (adrV),
        .adr_i          (adr),
        .is_store_i     (isStore),
        .store_data_i   (storeData),
        .access_size_i  (accessSize),
        .load_data_o    (loadData),
        .access_fault_o (accessFault),
        .timer_irq_o    (timerIrq),
        .tohost_v_o     (tohostV),
        .tohost_data_o  (tohostData)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        checkLoad;
        logic [31:0] expLoad;
        logic        expFault;
        logic        expIrq;
        logic        expTohostV;
        logic [31:0] expTohostData;
    } exp_t;

    exp_t sbQ[$];
    exp_t monEntry;

    // Reference model state: RAM as individual bytes keyed by offset from RAM_BASE.
    logic [7:0]  mMem [int unsigned];
    logic [63:0] mTime;
    logic [63:0] mCmp;
    logic        mIrq;
    logic        mTohostV;
    logic [31:0] mTohostData;

    int vectors     = 0;
    int miscompares = 0;
    int cycleNo     = 0;

    task automatic checkOutput(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mTime       = 64'd0;
        mCmp        = '1;
        mIrq        = 1'b0;
        mTohostV    = 1'b0;
        mTohostData = 32'd0;
    endtask

    function automatic logic inRam(input logic [31:0] a);
        longint d;
        d = longint'(a) - longint'(RAM_BASE);
        return (d >= 0) && (d < 4 * RAM_WORDS);
    endfunction

    function automatic logic inMmio(input logic [31:0] a);
        longint d;
        d = longint'(a) - longint'(MMIO_BASE);
        return (d >= 0) && (d < 32);
    endfunction

    function automatic int sizeBytes(input logic [2:0] sz);
        case (sz)
            SZ_B:    return 1;
            SZ_H:    return 2;
            SZ_W:    return 4;
            default: return 0;
        endcase
    endfunction

    task automatic ramRead(input logic [31:0] a, output logic [31:0] val, output logic known);
        int unsigned base;
        int unsigned off;
        base  = (a - RAM_BASE) & ~32'd3;
        off   = a & 32'd3;
        val   = 32'd0;
        known = 1'b1;
        for (int unsigned i = off; i < 4; i++) begin
            if (!mMem.exists(base + i)) known = 1'b0;
            else val = val | (32'(mMem[base + i]) << (8 * (i - off)));
        end
    endtask

    function automatic logic [31:0] mmioRead(input logic [31:0] off);
        case (off >> 2)
            0:       return mTime[31:0];
            1:       return mTime[63:32];
            2:       return mCmp[31:0];
            3:       return mCmp[63:32];
            4:       return mTohostData;
            default: return 32'd0;
        endcase
    endfunction

    // Predict this cycle's outputs, push them, then advance the model across the edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] a,
                                 input logic st, input logic [31:0] d, input logic [2:0] sz);
        exp_t        e;
        logic        ramHit;
        logic        mmioHit;
        logic        fault;
        logic [31:0] mOff;
        logic [63:0] nTime;
        logic        nIrq;
        logic        nV;
        int          nb;
        reset      = rst;
        adrV       = v;
        adr        = a;
        isStore    = st;
        storeData  = d;
        accessSize = sz;

        ramHit  = inRam(a);
        mmioHit = inMmio(a);
        mOff    = a - MMIO_BASE;
        fault   = v && (!(ramHit || mmioHit) || (mmioHit && (sz != SZ_W || mOff >= 32'h14)));

        e.cyc           = cycleNo;
        e.checkLoad     = 1'b1;
        e.expLoad       = 32'd0;
        e.expFault      = fault;
        e.expIrq        = mIrq;
        e.expTohostV    = mTohostV;
        e.expTohostData = mTohostData;
        if (v && !fault) begin
            if (st) e.checkLoad = 1'b0;
            else if (ramHit) ramRead(a, e.expLoad, e.checkLoad);
            else e.expLoad = mmioRead(mOff);
        end
        sbQ.push_back(e);

        nTime = mTime + 64'd1;
        nIrq  = (mTime >= mCmp);
        nV    = 1'b0;
        if (!rst && v && st && !fault) begin
            if (ramHit) begin
                nb = sizeBytes(sz);
                if (nb > 0 && (a % nb) == 0) begin
                    for (int i = 0; i < nb; i++) mMem[(a - RAM_BASE) + i] = d[8*i +: 8];
                end
            end else begin
                case (mOff >> 2)
                    0: nTime = {mTime[63:32], d};
                    1: nTime = {d, mTime[31:0]};
                    2: mCmp[31:0] = d;
                    3: mCmp[63:32] = d;
                    4: begin mTohostData = d; nV = 1'b1; end
                    default: ;
                endcase
            end
        end
        if (rst) begin
            modelReset();
        end else begin
            mTime    = nTime;
            mIrq     = nIrq;
            mTohostV = nV;
        end

        cycleNo++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, SZ_W);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] sz);
        applyStimulus(1'b0, 1'b1, a, 1'b0, 32'd0, sz);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        applyStimulus(1'b0, 1'b1, a, 1'b1, d, sz);
    endtask

    always @(negedge clk) begin
        if (sbQ.size() != 0) begin
            monEntry = sbQ.pop_front();
            if (monEntry.checkLoad) checkOutput("load_data_o", monEntry.cyc, loadData, monEntry.expLoad);
            checkOutput("access_fault_o", monEntry.cyc, 32'(accessFault), 32'(monEntry.expFault));
            checkOutput("timer_irq_o", monEntry.cyc, 32'(timerIrq), 32'(monEntry.expIrq));
            checkOutput("tohost_v_o", monEntry.cyc, 32'(tohostV), 32'(monEntry.expTohostV));
            checkOutput("tohost_data_o", monEntry.cyc, tohostData, monEntry.expTohostData);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int unsigned r;
        int unsigned w;
        logic [31:0] a;
        logic [31:0] data;
        logic [2:0]  sz;

        reset      = 1'b1;
        adrV       = 1'b0;
        adr        = 32'd0;
        isStore    = 1'b0;
        storeData  = 32'd0;
        accessSize = SZ_W;
        repeat (2) @(posedge clk);
        #1;
        modelReset();

        // Timer readback, compare/interrupt and carry into mtime_hi.
        repeat (10) idle();
        ld(MMIO_BASE + 32'h0, SZ_W);
        st(MMIO_BASE + 32'hC, 32'd0, SZ_W);
        st(MMIO_BASE + 32'h8, 32'd50, SZ_W);
        repeat (45) idle();
        st(MMIO_BASE + 32'hC, 32'hFFFF_FFFF, SZ_W);
        repeat (3) idle();
        st(MMIO_BASE + 32'h0, 32'hFFFF_FFFF, SZ_W);
        idle();
        ld(MMIO_BASE + 32'h4, SZ_W);
        ld(MMIO_BASE + 32'h8, SZ_W);

        // Give the RAM words used below known contents.
        for (int i = 0; i <= 16; i++) begin
            w = (i == 16) ? RAM_WORDS - 1 : i;
            st(RAM_BASE + 4 * w, $urandom, SZ_W);
        end

        st(RAM_BASE + 32'h6, 32'h0000_00A5, SZ_B);
        ld(RAM_BASE + 32'h4, SZ_W);
        ld(RAM_BASE + 32'h6, SZ_B);
        st(RAM_BASE + 32'h2, 32'hDEAD_BEEF, SZ_W);
        ld(RAM_BASE + 32'h0, SZ_W);
        st(RAM_BASE + 32'h5, 32'h1234_5678, SZ_H);
        ld(RAM_BASE + 32'h4, SZ_W);
        ld(RAM_BASE + 4 * RAM_WORDS, SZ_W);
        st(RAM_BASE + 4 * RAM_WORDS, 32'h5555_AAAA, SZ_W);
        ld(RAM_BASE + 4 * (RAM_WORDS - 1) + 1, SZ_B);

        // MMIO size fault, tohost pulses, reset mid-sequence and during a store.
        st(TOHOST, 32'h77, SZ_B);
        st(TOHOST, 32'd1, SZ_W);
        st(TOHOST, 32'd2, SZ_W);
        idle();
        st(TOHOST, 32'd3, SZ_W);
        applyStimulus(1'b1, 1'b1, TOHOST, 1'b1, 32'd4, SZ_W);
        idle();
        applyStimulus(1'b1, 1'b1, RAM_BASE + 32'h14, 1'b1, 32'hCAFE_F00D, SZ_W);
        ld(RAM_BASE + 32'h14, SZ_W);
        ld(MMIO_BASE + 32'h14, SZ_W);

        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 99);
            w    = $urandom_range(0, 16);
            if (w == 16) w = RAM_WORDS - 1;
            a    = RAM_BASE + 4 * w + $urandom_range(0, 3);
            data = $urandom;
            case ($urandom_range(0, 2))
                0:       sz = SZ_B;
                1:       sz = SZ_H;
                default: sz = SZ_W;
            endcase
            if (r < 3) begin
                applyStimulus(1'b1, 1'b1, a, 1'($urandom_range(0, 1)), data, sz);
            end else if (r < 10) begin
                applyStimulus(1'b0, 1'b0, a, 1'($urandom_range(0, 1)), data, sz);
            end else if (r < 48) begin
                ld(a, sz);
            end else if (r < 72) begin
                st(a, data, sz);
            end else if (r < 88) begin
                a = MMIO_BASE + 4 * $urandom_range(0, 7);
                if ($urandom_range(0, 4) != 0) sz = SZ_W;
                if ($urandom_range(0, 1) != 0) ld(a, sz);
                else st(a, data, sz);
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = RAM_BASE + 4 * RAM_WORDS + $urandom_range(0, 255);
                    1:       a = MMIO_BASE - 1 - $urandom_range(0, 15);
                    default: a = 32'h8000_0000 | $urandom;
                endcase
                applyStimulus(1'b0, 1'b1, a, 1'($urandom_range(0, 1)), data, sz);
            end
        end
        idle();

        for (int i = 0; i < 8 && sbQ.size() != 0; i++) @(negedge clk);
        if (sbQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
